// File: rtl/apb_ctrl_status_regbank.sv
// APB3 slave register bank: RW control words, RO status words, W1C irq pending, irq enable, wait states.
// Optional macro STATUS_SYNC_EN adds a 2-flop synchronizer on status_in.
module apb_ctrl_status_regbank #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       NUM_CTRL    = 4,
  parameter int unsigned       NUM_STAT    = 2,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] CTRL_RST    = '0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_out,
  input  logic [NUM_STAT*DATA_W-1:0]   status_in,
  output logic                         irq
);

  localparam int unsigned IDX_W     = ADDR_W - 2;
  localparam int unsigned IDX_PEND  = NUM_CTRL + NUM_STAT;
  localparam int unsigned IDX_EN    = IDX_PEND + 1;
  localparam int unsigned CNT_W     = 4;
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_ctrl [NUM_CTRL];
  logic [DATA_W-1:0]       r_pend;
  logic [DATA_W-1:0]       r_en;
  logic [DATA_W-1:0]       r_prev;

  logic [NUM_STAT*DATA_W-1:0] w_status;
  logic [IDX_W-1:0]           w_idx;
  logic [31:0]                w_idx32;
  logic                       w_setup;
  logic                       w_commit;
  logic                       w_wr;
  logic                       w_oor;
  logic [DATA_W-1:0]          w_rdata;
  logic [DATA_W-1:0]          w_clr;
  logic [DATA_W-1:0]          w_rise;
  logic                       w_unused_ok;

`ifdef STATUS_SYNC_EN
  logic [NUM_STAT*DATA_W-1:0] r_sync1;
  logic [NUM_STAT*DATA_W-1:0] r_sync2;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= status_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_status = r_sync2;
`else
  assign w_status = status_in;
`endif

  assign w_idx       = paddr[ADDR_W-1:2];
  assign w_idx32     = 32'(w_idx);
  assign w_setup     = psel & ~penable;
  assign w_commit    = ((r_state == S_IDLE) && w_setup && ZERO_WAIT) ||
                       ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));
  assign w_wr        = w_commit & pwrite;
  assign w_oor       = (w_idx32 > IDX_EN);
  assign w_clr       = (w_wr && (w_idx32 == IDX_PEND)) ? pwdata : '0;
  assign w_rise      = w_status[DATA_W-1:0] & ~r_prev;
  assign w_unused_ok = &{1'b0, paddr[1:0]};

  // Read mux over the whole word map; out-of-range reads return 0.
  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (w_idx32 == i) w_rdata = r_ctrl[i];
    end
    for (int unsigned i = 0; i < NUM_STAT; i++) begin
      if (w_idx32 == NUM_CTRL + i) w_rdata = w_status[i*DATA_W +: DATA_W];
    end
    if (w_idx32 == IDX_PEND) w_rdata = r_pend;
    if (w_idx32 == IDX_EN)   w_rdata = r_en;
  end

  always_comb begin
    ctrl_out = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      ctrl_out[i*DATA_W +: DATA_W] = r_ctrl[i];
    end
  end

  // Transfer sequencing; response outputs are only non-zero in the RESP cycle.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_cnt   <= CNT_W'(WAIT_STATES);
            r_state <= ZERO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        pready  <= 1'b1;
        pslverr <= w_oor;
        prdata  <= pwrite ? '0 : w_rdata;
      end
    end
  end

  // Register file; a new status rising edge beats a same-cycle W1C of that bit.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= CTRL_RST;
      r_pend <= '0;
      r_en   <= '0;
      irq    <= 1'b0;
      r_prev <= w_status[DATA_W-1:0];
    end else begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        if (w_wr && (w_idx32 == i)) r_ctrl[i] <= pwdata;
      end
      if (w_wr && (w_idx32 == IDX_EN)) r_en <= pwdata;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      r_prev <= w_status[DATA_W-1:0];
      irq    <= |(r_pend & r_en);
    end
  end

endmodule

// File: tb/tb_apb_ctrl_status_regbank.sv
// Self-checking bench: two instances (0 and 3 wait states) on a shared APB bus, checked each cycle
// against a transaction-level model, plus directed literal checks.
module tb_apb_ctrl_status_regbank;

  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 12;
  localparam int unsigned NC       = 4;
  localparam int unsigned NS       = 2;
  localparam int unsigned IDX_PEND = NC + NS;
  localparam int unsigned IDX_EN   = IDX_PEND + 1;
  localparam logic [31:0] RST_VAL  = 32'h5A;
  localparam int          WS0      = 0;
  localparam int          WS1      = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             preset, psel, penable, pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [NS*DW-1:0] status_in;
  logic [DW-1:0]    prdata   [2];
  logic             pready   [2];
  logic             pslverr  [2];
  logic             irq      [2];
  logic [NC*DW-1:0] ctrl_out [2];

  apb_ctrl_status_regbank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CTRL(NC), .NUM_STAT(NS), .WAIT_STATES(WS0), .CTRL_RST(RST_VAL)
  ) u_dut0 (
    .pclk(clk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .ctrl_out(ctrl_out[0]), .status_in(status_in), .irq(irq[0])
  );

  apb_ctrl_status_regbank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CTRL(NC), .NUM_STAT(NS), .WAIT_STATES(WS1), .CTRL_RST(RST_VAL)
  ) u_dut1 (
    .pclk(clk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .ctrl_out(ctrl_out[1]), .status_in(status_in), .irq(irq[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
  endfunction

  // ---------------- behavioural model (per instance) ----------------
  logic [31:0]      m_ctrl [2][NC];
  logic [31:0]      m_pend [2];
  logic [31:0]      m_en   [2];
  logic [31:0]      m_prev [2];
  logic             m_irq  [2];
  bit               m_busy [2];
  int               m_left [2];
  logic             m_rdy  [2];
  logic             m_err  [2];
  logic             m_rd   [2];
  logic [31:0]      m_rdata[2];
  logic [NS*DW-1:0] m_sh1  [2];
  logic [NS*DW-1:0] m_sh2  [2];

  function automatic int ws(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic logic [NS*DW-1:0] eff_status(input int k);
`ifdef STATUS_SYNC_EN
    return m_sh2[k];
`else
    return status_in;
`endif
  endfunction

  task automatic model_step(input int k);
    logic [NS*DW-1:0] st;
    logic [31:0]      s0, clr, rise;
    logic             was_rdy, irq_new;
    int               idx;
    st = eff_status(k);
    s0 = st[31:0];
    if (preset) begin
      for (int i = 0; i < NC; i++) m_ctrl[k][i] = RST_VAL;
      m_pend[k] = '0; m_en[k] = '0; m_irq[k] = 1'b0; m_prev[k] = s0;
      m_busy[k] = 1'b0; m_left[k] = 0;
      m_rdy[k] = 1'b0; m_err[k] = 1'b0; m_rd[k] = 1'b0; m_rdata[k] = '0;
      m_sh1[k] = '0; m_sh2[k] = '0;
    end else begin
      was_rdy = m_rdy[k];
      m_rdy[k] = 1'b0; m_err[k] = 1'b0; m_rd[k] = 1'b0; m_rdata[k] = '0;
      clr     = '0;
      rise    = s0 & ~m_prev[k];
      irq_new = |(m_pend[k] & m_en[k]);
      if (!m_busy[k] && !was_rdy && psel && !penable) begin
        m_busy[k] = 1'b1;
        m_left[k] = ws(k);
      end else if (m_busy[k]) begin
        m_left[k]--;
      end
      if (m_busy[k] && m_left[k] == 0) begin
        m_busy[k] = 1'b0;
        m_rdy[k]  = 1'b1;
        m_rd[k]   = !pwrite;
        idx       = int'(paddr) / 4;
        if (idx > int'(IDX_EN)) m_err[k] = 1'b1;
        else if (pwrite) begin
          if (idx < int'(NC))            m_ctrl[k][idx] = pwdata;
          else if (idx == int'(IDX_PEND)) clr = pwdata;
          else if (idx == int'(IDX_EN))   m_en[k] = pwdata;
        end else begin
          if (idx < int'(NC))              m_rdata[k] = m_ctrl[k][idx];
          else if (idx < int'(IDX_PEND))   m_rdata[k] = st[(idx - int'(NC))*32 +: 32];
          else if (idx == int'(IDX_PEND))  m_rdata[k] = m_pend[k];
          else                             m_rdata[k] = m_en[k];
        end
      end
      m_pend[k] = (m_pend[k] & ~clr) | rise;
      m_prev[k] = s0;
      m_irq[k]  = irq_new;
      m_sh2[k]  = m_sh1[k];
      m_sh1[k]  = status_in;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d.pready", k),  32'(pready[k]),  32'(m_rdy[k]));
        check($sformatf("dut%0d.pslverr", k), 32'(pslverr[k]), 32'(m_err[k]));
        check($sformatf("dut%0d.irq", k),     32'(irq[k]),     32'(m_irq[k]));
        if (!m_rdy[k] || m_rd[k])
          check($sformatf("dut%0d.prdata", k), prdata[k], m_rdy[k] ? m_rdata[k] : 32'h0);
        for (int i = 0; i < NC; i++)
          check($sformatf("dut%0d.ctrl%0d", k, i), ctrl_out[k][i*DW +: DW], m_ctrl[k][i]);
      end
    end
  end

  // ---------------- bus master ----------------
  logic [31:0] x_rd  [2];
  logic        x_err [2];
  int          x_cyc [2];

  // st_at: access cycle (0 = setup) at which status word 0 is changed to st_val; -1 = never.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                      input int st_at, input logic [31:0] st_val);
    bit got0 = 1'b0, got1 = 1'b0;
    int cyc  = 0;
    x_rd[0] = '0; x_rd[1] = '0; x_err[0] = 1'b0; x_err[1] = 1'b0; x_cyc[0] = -1; x_cyc[1] = -1;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    if (st_at == 0) status_in[31:0] = st_val;
    while (!(got0 && got1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      penable = 1'b1;
      if (st_at == cyc) status_in[31:0] = st_val;
      if (!got0 && pready[0] === 1'b1) begin
        got0 = 1'b1; x_cyc[0] = cyc; x_rd[0] = prdata[0]; x_err[0] = pslverr[0];
      end
      if (!got1 && pready[1] === 1'b1) begin
        got1 = 1'b1; x_cyc[1] = cyc; x_rd[1] = prdata[1]; x_err[1] = pslverr[1];
      end
    end
    if (!(got0 && got1)) begin
      n_checks++;
      $display("FAIL xfer_timeout: pready seen %0b/%0b, want 1/1 within 20 cycles", got0, got1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    preset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset values
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NC; i++) check($sformatf("rst.dut%0d.ctrl%0d", k, i), ctrl_out[k][i*DW +: DW], 32'h5A);
      check($sformatf("rst.dut%0d.irq", k),    32'(irq[k]),    32'h0);
      check($sformatf("rst.dut%0d.pready", k), 32'(pready[k]), 32'h0);
      check($sformatf("rst.dut%0d.prdata", k), prdata[k],      32'h0);
    end
    @(negedge clk);
    preset = 1'b0;

    // Control write/read and latency
    xfer(1'b1, 12'h004, 32'hDEADBEEF, -1, 0);
    check("lat.ws0", 32'(x_cyc[0]), 32'd1);
    check("lat.ws3", 32'(x_cyc[1]), 32'd4);
    xfer(1'b0, 12'h004, 32'h0, -1, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd1.dut%0d", k), x_rd[k], 32'hDEADBEEF);
      check($sformatf("ctrl1.dut%0d", k), ctrl_out[k][63:32], 32'hDEADBEEF);
    end

    // Interrupt pending / enable / W1C
    idle(2);
    @(negedge clk); status_in[31:0] = 32'h8;
    idle(3);
    xfer(1'b1, AW'(IDX_EN * 4), 32'h8, -1, 0);
    idle(5);
    for (int k = 0; k < 2; k++) check($sformatf("irq_set.dut%0d", k), 32'(irq[k]), 32'h1);
    xfer(1'b0, AW'(IDX_PEND * 4), 32'h0, -1, 0);
    for (int k = 0; k < 2; k++) check($sformatf("pend_rd.dut%0d", k), x_rd[k], 32'h8);
    xfer(1'b1, AW'(IDX_PEND * 4), 32'h8, -1, 0);
    idle(5);
    for (int k = 0; k < 2; k++) check($sformatf("irq_clr.dut%0d", k), 32'(irq[k]), 32'h0);
    @(negedge clk); status_in[31:0] = 32'h0;
    idle(4);
    xfer(1'b1, AW'(IDX_PEND * 4), 32'h8, 0, 32'h8);
    idle(4);
    xfer(1'b0, AW'(IDX_PEND * 4), 32'h0, -1, 0);
`ifndef STATUS_SYNC_EN
    check("setwins.ws0", x_rd[0], 32'h8);
    check("setwins.ws3_early_rise", x_rd[1], 32'h0);
`endif
    @(negedge clk); status_in[31:0] = 32'h0;
    idle(4);
    xfer(1'b1, AW'(IDX_PEND * 4), 32'h8, 3, 32'h8);
    idle(4);
    xfer(1'b0, AW'(IDX_PEND * 4), 32'h0, -1, 0);
`ifndef STATUS_SYNC_EN
    check("setwins.ws0_late_rise", x_rd[0], 32'h8);
    check("setwins.ws3", x_rd[1], 32'h8);
`endif

    // Out-of-range index
    xfer(1'b0, AW'((IDX_EN + 1) * 4), 32'h0, -1, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("oor_rd.err.dut%0d", k), 32'(x_err[k]), 32'h1);
      check($sformatf("oor_rd.data.dut%0d", k), x_rd[k], 32'h0);
    end
    xfer(1'b1, AW'((IDX_EN + 1) * 4), 32'hFFFFFFFF, -1, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("oor_wr.err.dut%0d", k), 32'(x_err[k]), 32'h1);
      check($sformatf("oor_wr.ctrl1.dut%0d", k), ctrl_out[k][63:32], 32'hDEADBEEF);
    end

    // Status word is read-only
    @(negedge clk); status_in[63:32] = 32'hAB;
    idle(3);
    xfer(1'b1, AW'((NC + 1) * 4), 32'h55, -1, 0);
    for (int k = 0; k < 2; k++) check($sformatf("stat_wr.err.dut%0d", k), 32'(x_err[k]), 32'h0);
    xfer(1'b0, AW'((NC + 1) * 4), 32'h0, -1, 0);
    for (int k = 0; k < 2; k++) check($sformatf("stat_rd.dut%0d", k), x_rd[k], 32'hAB);

    // Reset during WAIT of the 3-wait-state instance
    pulses = 0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h1111;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); preset = 1'b1;
    @(negedge clk); preset = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pready[1] === 1'b1) pulses++;
    end
    check("rst_wait.pready_pulses", 32'(pulses), 32'h0);
    check("rst_wait.ctrl2", ctrl_out[1][95:64], 32'h5A);

    // Status readback lag
    @(negedge clk); status_in = '0;
    idle(4);
    xfer(1'b0, AW'(NC * 4), 32'h0, 0, 32'h1234);
`ifdef STATUS_SYNC_EN
    check("sync.ws0_too_early", x_rd[0], 32'h0);
`else
    check("sync.ws0", x_rd[0], 32'h1234);
`endif
    check("sync.ws3", x_rd[1], 32'h1234);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      logic [AW-1:0] a;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        do_reset();
      end else if (r < 18) begin
        @(negedge clk);
        status_in = {$urandom, $urandom};
        idle(int'($urandom_range(1, 2)));
      end else begin
        if ($urandom_range(0, 9) == 0) a = AW'($urandom);
        else a = AW'($urandom_range(0, IDX_EN + 2) * 4 + $urandom_range(0, 3));
        xfer(1'($urandom), a, $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, $urandom);
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
    end

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
